branch_predictor: RTL and testbench

//  Parametrised dynamic conditional-branch predictor for the 5-stage MIPS pipeline; replaces static resolve-in-D.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/branch_predictor_if.sv | 42 ++++
 rtl/bp_pht.sv | 35 +++
 rtl/branch_predictor.sv | 97 +++++++++
 tb/tb_branch_predictor.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared constants and helpers for the dynamic branch predictor.
//   - 2-bit saturating counter encodings (strongly/weakly not-taken/taken)
//   - index-hash mode selectors
//   - sat2_next: next value of a 2-bit saturating counter given an outcome
package bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic take);
        logic [1:0] nxt;
        if (take) begin
            nxt = (cnt == BP_ST) ? BP_ST : cnt + 2'b01;
        end else begin
            nxt = (cnt == BP_SNT) ? BP_SNT : cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> predictor connection.
//   D side: branchD, pcD, stallD, flushD in; pred_takeD, pred_idxD, ghr_snapD out.
//   E side: branchE, takeE, pred_takeE, pred_idxE, ghr_snapE, stallE in;
//           mispredictE, branch_cnt, mispred_cnt out.
// master = pipeline (drives stage info), slave = predictor.
interface branch_predictor_if #(
    parameter int IDX_W = 10,
    parameter int GHR_W = 8,
    parameter int CNT_W = 32
);
    logic             branchD;
    logic [31:0]      pcD;
    logic             stallD;
    logic             flushD;
    logic             pred_takeD;
    logic [IDX_W-1:0] pred_idxD;
    logic [GHR_W-1:0] ghr_snapD;

    logic             branchE;
    logic             takeE;
    logic             pred_takeE;
    logic [IDX_W-1:0] pred_idxE;
    logic [GHR_W-1:0] ghr_snapE;
    logic             stallE;
    logic             mispredictE;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output branchD, pcD, stallD, flushD,
        output branchE, takeE, pred_takeE, pred_idxE, ghr_snapE, stallE,
        input  pred_takeD, pred_idxD, ghr_snapD,
        input  mispredictE, branch_cnt, mispred_cnt
    );

    modport slave (
        input  branchD, pcD, stallD, flushD,
        input  branchE, takeE, pred_takeE, pred_idxE, ghr_snapE, stallE,
        output pred_takeD, pred_idxD, ghr_snapD,
        output mispredictE, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2**IDX_W entries of 2-bit saturating counters.
//   clk, rst   : clock, asynchronous active-low reset (all entries -> weakly not-taken)
//   rdIdx/rdCnt: combinational read port
//   wrEn/wrIdx/wrTake: synchronous training port; the entry moves one step toward wrTake
// A read of an index being written this cycle returns the old value.
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [1:0]       rdCnt,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic             wrTake
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] mem [ENTRIES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= BP_WNT;
            end
        end else if (wrEn) begin
            mem[wrIdx] <= sat2_next(mem[wrIdx], wrTake);
        end
    end

    assign rdCnt = mem[rdIdx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor (bimodal or gshare).
//   clk, rst : clock, asynchronous active-low reset
//   bp       : slave side of branch_predictor_if
// D: looks up the PHT, predicts, speculatively shifts the global history.
// E: trains the PHT on the resolved outcome, repairs history on a mispredict,
//    keeps saturating resolve/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int GHR_W = 8,
    parameter int MODE  = BP_MODE_GSHARE,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    branch_predictor_if.slave bp
);
    if (GHR_W > IDX_W || GHR_W < 1) begin : gen_cfg_err
        $error("branch_predictor: GHR_W must lie in 1..IDX_W");
    end

    logic [GHR_W-1:0] ghrQ, ghrD;
    logic [CNT_W-1:0] branchCntQ, mispredCntQ;
    logic [IDX_W-1:0] pcIdx, ghrExt, lookupIdx;
    logic [1:0]       rdCnt;
    logic             updOk, resolve, mispredict;
    logic [GHR_W-1:0] specIn, repairIn;
    logic             unusedPc;

    // Only the word-index bits of the PC feed the hash.
    assign pcIdx    = bp.pcD[IDX_W+1:2];
    assign unusedPc = ^{bp.pcD[31:IDX_W+2], bp.pcD[1:0]};

    always_comb begin
        ghrExt = '0;
        ghrExt[GHR_W-1:0] = ghrQ;
    end

    assign lookupIdx = (MODE == BP_MODE_GSHARE) ? (pcIdx ^ ghrExt) : pcIdx;

    bp_pht #(
        .IDX_W (IDX_W)
    ) uPht (
        .clk    (clk),
        .rst    (rst),
        .rdIdx  (lookupIdx),
        .rdCnt  (rdCnt),
        .wrEn   (resolve),
        .wrIdx  (bp.pred_idxE),
        .wrTake (bp.takeE)
    );

    assign bp.pred_takeD = bp.branchD & rdCnt[1];
    assign bp.pred_idxD  = lookupIdx;
    assign bp.ghr_snapD  = ghrQ;

    assign updOk      = bp.branchD & ~bp.stallD & ~bp.flushD;
    assign resolve    = bp.branchE & ~bp.stallE;
    assign mispredict = resolve & (bp.takeE != bp.pred_takeE);
    assign bp.mispredictE = mispredict;

    // History shift written as (h << 1) | bit so it also works for GHR_W == 1.
    always_comb begin
        specIn      = '0;
        specIn[0]   = bp.pred_takeD;
        repairIn    = '0;
        repairIn[0] = bp.takeE;
        ghrD        = ghrQ;
        // A repair means the D instruction is wrong-path, so it wins.
        if (mispredict) begin
            ghrD = (bp.ghr_snapE << 1) | repairIn;
        end else if (updOk) begin
            ghrD = (ghrQ << 1) | specIn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghrQ        <= '0;
            branchCntQ  <= '0;
            mispredCntQ <= '0;
        end else begin
            ghrQ <= ghrD;
            if (resolve && branchCntQ != '1) begin
                branchCntQ <= branchCntQ + 1'b1;
            end
            if (mispredict && mispredCntQ != '1) begin
                mispredCntQ <= mispredCntQ + 1'b1;
            end
        end
    end

    assign bp.branch_cnt  = branchCntQ;
    assign bp.mispred_cnt = mispredCntQ;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    branch_predictor_if #(.IDX_W(10), .GHR_W(8), .CNT_W(32)) bus0 ();
    branch_predictor_if #(.IDX_W(10), .GHR_W(2), .CNT_W(32)) bus1 ();

    branch_predictor #(
        .IDX_W (10),
        .GHR_W (8),
        .MODE  (BP_MODE_BIMODAL),
        .CNT_W (32)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bp  (bus0)
    );

    branch_predictor #(
        .IDX_W (10),
        .GHR_W (2),
        .MODE  (BP_MODE_GSHARE),
        .CNT_W (32)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bp  (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        bus0.branchD = 0; bus0.pcD = '0; bus0.stallD = 0; bus0.flushD = 0;
        bus0.branchE = 0; bus0.takeE = 0; bus0.pred_takeE = 0;
        bus0.pred_idxE = '0; bus0.ghr_snapE = '0; bus0.stallE = 0;
        bus1.branchD = 0; bus1.pcD = '0; bus1.stallD = 0; bus1.flushD = 0;
        bus1.branchE = 0; bus1.takeE = 0; bus1.pred_takeE = 0;
        bus1.pred_idxE = '0; bus1.ghr_snapE = '0; bus1.stallE = 0;
    endtask

    // Resolve one branch on dut0 in E for a single cycle.
    task automatic resolve0(input logic [9:0] idx, input logic take, input logic pred,
                            input logic [7:0] snap);
        bus0.branchE = 1; bus0.pred_idxE = idx; bus0.takeE = take;
        bus0.pred_takeE = pred; bus0.ghr_snapE = snap;
    endtask

    logic       p1;
    logic [9:0] idx1;
    logic [1:0] snap1;
    logic       outcome;

    initial begin
        idleAll();
        #12;
        rst = 1;
        tick();

        // 1: reset state lookup
        bus0.branchD = 1; bus0.pcD = 32'h0000_0080;
        #1;
        check("rst_pred", bus0.pred_takeD, 0);
        check("rst_ghr", bus0.ghr_snapD, 0);
        check("rst_bcnt", bus0.branch_cnt, 0);
        check("rst_idx", bus0.pred_idxD, 32'h20);
        check("rst_misE", bus0.mispredictE, 0);
        bus0.branchD = 0;

        // 2: two taken resolves predicted not-taken
        resolve0(10'h20, 1, 0, 8'h00);
        #1;
        check("t2_mis1", bus0.mispredictE, 1);
        tick();
        check("t2_mis2", bus0.mispredictE, 1);
        tick();
        bus0.branchE = 0;
        #1;
        check("t2_mcnt", bus0.mispred_cnt, 2);
        check("t2_bcnt", bus0.branch_cnt, 2);
        check("t2_pht", dut0.uPht.mem[32], 2'b11);
        check("t2_ghr", bus0.ghr_snapD, 8'h01);
        bus0.branchD = 1; bus0.pcD = 32'h80;
        #1;
        check("t2_pred", bus0.pred_takeD, 1);
        bus0.branchD = 0;

        // 3: saturation at 11, then one not-taken
        resolve0(10'h20, 1, 1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_mis", bus0.mispredictE, 0);
            tick();
        end
        check("t3_sat", dut0.uPht.mem[32], 2'b11);
        resolve0(10'h20, 0, 1, 8'h00);
        tick();
        bus0.branchE = 0;
        #1;
        check("t3_dec", dut0.uPht.mem[32], 2'b10);
        bus0.branchD = 1; bus0.pcD = 32'h80;
        #1;
        check("t3_pred", bus0.pred_takeD, 1);
        check("t3_bcnt", bus0.branch_cnt, 6);
        check("t3_mcnt", bus0.mispred_cnt, 3);

        // 5a: repair collides with a speculative D shift (branchD still 1, predicts taken)
        resolve0(10'h10, 1, 0, 8'hA5);
        tick();
        bus0.branchD = 0; bus0.branchE = 0;
        #1;
        check("t5_ghr", bus0.ghr_snapD, 8'h4B);
        check("t5_bcnt", bus0.branch_cnt, 7);
        check("t5_pht", dut0.uPht.mem[16], 2'b10);

        // 5b: branch held in E by stallE for 3 cycles
        resolve0(10'h30, 1, 0, 8'h00);
        bus0.stallE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_stall_mis", bus0.mispredictE, 0);
            tick();
        end
        check("t5_stall_cnt", bus0.branch_cnt, 7);
        bus0.stallE = 0;
        #1;
        check("t5_rel_mis", bus0.mispredictE, 1);
        tick();
        bus0.branchE = 0;
        #1;
        check("t5_rel_bcnt", bus0.branch_cnt, 8);
        check("t5_rel_mcnt", bus0.mispred_cnt, 5);
        check("t5_rel_pht", dut0.uPht.mem[48], 2'b10);

        // 4: gshare with 2-bit history learns strict alternation on pc 0x100
        for (int i = 0; i < 40; i++) begin
            outcome = (i % 2 == 0);
            bus1.branchD = 1; bus1.pcD = 32'h100;
            #1;
            p1 = bus1.pred_takeD; idx1 = bus1.pred_idxD; snap1 = bus1.ghr_snapD;
            tick();
            bus1.branchD = 0;
            bus1.branchE = 1; bus1.takeE = outcome; bus1.pred_takeE = p1;
            bus1.pred_idxE = idx1; bus1.ghr_snapE = snap1;
            #1;
            if (i >= 20) check("t4_alt_mis", bus1.mispredictE, 0);
            tick();
            bus1.branchE = 0;
        end
        check("t4_bcnt", bus1.branch_cnt, 40);

        // 6: fourth trained entry, then reset mid-cycle with an update in flight
        resolve0(10'h05, 1, 1, 8'h00);
        tick();
        check("t6_pre", dut0.uPht.mem[5], 2'b10);
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        check("t6_e20", dut0.uPht.mem[32], 2'b01);
        check("t6_e10", dut0.uPht.mem[16], 2'b01);
        check("t6_e30", dut0.uPht.mem[48], 2'b01);
        check("t6_e05", dut0.uPht.mem[5], 2'b01);
        check("t6_ghr", bus0.ghr_snapD, 0);
        check("t6_bcnt", bus0.branch_cnt, 0);
        check("t6_mcnt", bus0.mispred_cnt, 0);
        check("t6_bcnt1", bus1.branch_cnt, 0);
        check("t6_misE", bus0.mispredictE, 0);
        tick();
        check("t6_hold", dut0.uPht.mem[5], 2'b01);
        bus0.branchE = 0;
        rst = 1;
        bus0.branchD = 1; bus0.pcD = 32'h80;
        #1;
        check("t6_pred", bus0.pred_takeD, 0);
        bus0.branchD = 0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
